// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: encoding-type one-hots, register index
// width and the issue controller state type.
package riscv_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int TYP_W     = 7;

   localparam logic [TYP_W-1:0] TYP_UNRECOGNISED = 7'd0;
   localparam logic [TYP_W-1:0] TYP_R            = 7'd1;
   localparam logic [TYP_W-1:0] TYP_I            = 7'd2;
   localparam logic [TYP_W-1:0] TYP_S            = 7'd4;
   localparam logic [TYP_W-1:0] TYP_B            = 7'd8;
   localparam logic [TYP_W-1:0] TYP_U            = 7'd16;
   localparam logic [TYP_W-1:0] TYP_J            = 7'd32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_HELD,
      ST_TRAP
   } issue_state_e;

   // x0 is hardwired, so it never counts as a pending write.
   function automatic logic reg_pending(input logic [NUM_REGS-1:0] busy, input reg_idx_t idx);
      return (idx != '0) && busy[idx];
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap plus issued-not-retired counter; a set and a clear of
// the same register in one cycle leaves the bit set.
module reg_scoreboard
   import riscv_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_en,
   input  reg_idx_t            set_rd,
   input  logic                clr_en,
   input  reg_idx_t            clr_rd,
   output logic [NUM_REGS-1:0] busy,
   output logic [3:0]          inflight
);

   logic [NUM_REGS-1:0] busy_next;
   logic [3:0]          inflight_next;

   // Clear first so a same-cycle set overrides it; count saturates at zero.
   always_comb begin
      busy_next     = busy;
      inflight_next = inflight;
      if (clr_en && (clr_rd != '0)) begin
         busy_next[clr_rd] = 1'b0;
      end
      if (set_en && (set_rd != '0)) begin
         busy_next[set_rd] = 1'b1;
      end
      if (set_en && !clr_en) begin
         inflight_next = inflight + 4'd1;
      end else if (!set_en && clr_en && (inflight != 4'd0)) begin
         inflight_next = inflight - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         inflight <= 4'd0;
      end else begin
         busy     <= busy_next;
         inflight <= inflight_next;
      end
   end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: holds one decoded instruction and releases it to
// execute once no RAW/WAW/in-flight hazard exists against the scoreboard.
module issue_ctrl
   import riscv_pkg::*;
#(
   parameter int N_param      = 32,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_flush,
   input  logic               dec_valid_i,
   output logic               dec_ready_o,
   input  logic [4:0]         dec_rd_i,
   input  logic [4:0]         dec_rs1_i,
   input  logic [4:0]         dec_rs2_i,
   input  logic [6:0]         dec_typ_i,
   input  logic [N_param-1:0] dec_imm_i,
   output logic               iss_valid_o,
   input  logic               iss_ready_i,
   output logic [4:0]         iss_rd_o,
   output logic [4:0]         iss_rs1_o,
   output logic [4:0]         iss_rs2_o,
   output logic [6:0]         iss_typ_o,
   output logic [N_param-1:0] iss_imm_o,
   input  logic               wb_valid_i,
   input  logic [4:0]         wb_rd_i,
   output logic [31:0]        busy_o,
   output logic [3:0]         inflight_o,
   output logic               stall_o,
   output logic               illegal_o
);

   issue_state_e       state;
   issue_state_e       state_next;
   logic               hazard;
   logic               issue_fire;
   logic               capture;
   logic [4:0]         hold_rd;
   logic [4:0]         hold_rs1;
   logic [4:0]         hold_rs2;
   logic [6:0]         hold_typ;
   logic [N_param-1:0] hold_imm;

   reg_scoreboard u_scoreboard (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .set_en   (issue_fire),
      .set_rd   (hold_rd),
      .clr_en   (wb_valid_i),
      .clr_rd   (wb_rd_i),
      .busy     (busy_o),
      .inflight (inflight_o)
   );

   // Hazards look only at registered scoreboard state: no retire bypass.
   assign hazard = reg_pending(busy_o, hold_rs1)
                 | reg_pending(busy_o, hold_rs2)
                 | reg_pending(busy_o, hold_rd)
                 | (inflight_o == 4'(MAX_INFLIGHT));

   always_comb begin
      iss_valid_o = (state == ST_HELD) & i_en & ~i_flush & ~hazard;
      issue_fire  = iss_valid_o & iss_ready_i;
      dec_ready_o = i_en & ~i_flush & ((state == ST_EMPTY) | issue_fire);
      capture     = dec_valid_i & dec_ready_o;
      stall_o     = (state == ST_HELD) & ~issue_fire;
      illegal_o   = (state == ST_TRAP);
      state_next  = state;
      if (i_flush) begin
         state_next = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY, ST_HELD: begin
               if (capture) begin
                  state_next = (dec_typ_i == TYP_UNRECOGNISED) ? ST_TRAP : ST_HELD;
               end else if (issue_fire) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Flush drops the payload so a squashed instruction never lingers on iss_*.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_rd  <= '0;
         hold_rs1 <= '0;
         hold_rs2 <= '0;
         hold_typ <= '0;
         hold_imm <= '0;
      end else if (i_flush) begin
         hold_rd  <= '0;
         hold_rs1 <= '0;
         hold_rs2 <= '0;
         hold_typ <= '0;
         hold_imm <= '0;
      end else if (capture) begin
         hold_rd  <= dec_rd_i;
         hold_rs1 <= dec_rs1_i;
         hold_rs2 <= dec_rs2_i;
         hold_typ <= dec_typ_i;
         hold_imm <= dec_imm_i;
      end
   end

   assign iss_rd_o  = hold_rd;
   assign iss_rs1_o = hold_rs1;
   assign iss_rs2_o = hold_rs2;
   assign iss_typ_o = hold_typ;
   assign iss_imm_o = hold_imm;

endmodule
